// File: rtl/sccb_pkg.sv
// ============================================================================
// Module      : sccb_pkg
// Description : Shared state encoding, command flags and defaults for the
//               SCCB register-access engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_CMD     = 3'd1,
        TX_BYTES   = 3'd2,
        WAIT_IDLE1 = 3'd3,
        RD_CMD     = 3'd4,
        RX         = 3'd5,
        WAIT_IDLE  = 3'd6,
        RESP       = 3'd7
    } sccb_state_t;

    typedef struct packed {
        logic start;
        logic read;
        logic write;
        logic write_multiple;
        logic stop;
    } sccb_cmd_t;

    localparam logic [6:0]  OV7670_ADDR      = 7'h21;
    localparam logic [15:0] DEFAULT_PRESCALE = 16'd63;

endpackage

`default_nettype wire

// File: rtl/sccb_byte_serializer.sv
// ============================================================================
// Module      : sccb_byte_serializer
// Description : Presents a loaded word MSB-first as an 8-bit stream with tlast.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sccb_byte_serializer
    import sccb_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              enable,
    output logic [7:0]        tdata,
    output logic              tvalid,
    output logic              tlast,
    input  logic              tready
);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    assign tvalid = enable && (r_cnt != '0);
    assign tlast  = (r_cnt == CNT_W'(1));
    assign tdata  = r_shift[WORD_W-1 -: 8];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= load_word;
            r_cnt   <= load_count;
        end else if (tvalid && tready) begin
            r_shift <= r_shift << 8;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sccb_reg_access.sv
// ============================================================================
// Module      : sccb_reg_access
// Description : Single register read/write engine driving an AXI-stream i2c
//               master with SCCB-style sequencing and a transaction timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sccb_reg_access
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = OV7670_ADDR,
    parameter int          REG_W       = 8,
    parameter int          DATA_W      = 8,
    parameter logic [15:0] PRESCALE    = DEFAULT_PRESCALE,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [REG_W-1:0]  req_reg,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [6:0]        s_axis_cmd_address,
    output logic              s_axis_cmd_start,
    output logic              s_axis_cmd_read,
    output logic              s_axis_cmd_write,
    output logic              s_axis_cmd_write_multiple,
    output logic              s_axis_cmd_stop,
    output logic              s_axis_cmd_valid,
    input  logic              s_axis_cmd_ready,
    output logic [7:0]        s_axis_data_tdata,
    output logic              s_axis_data_tvalid,
    input  logic              s_axis_data_tready,
    output logic              s_axis_data_tlast,
    input  logic [7:0]        m_axis_data_tdata,
    input  logic              m_axis_data_tvalid,
    output logic              m_axis_data_tready,
    input  logic              m_axis_data_tlast,
    input  logic              busy,
    input  logic              missed_ack,
    output logic [15:0]       prescale,
    output logic              stop_on_idle
);

    localparam int c_WORD_W = REG_W + DATA_W;
    localparam int c_CNT_W  = $clog2(c_WORD_W/8 + 1);
    localparam int c_RXC_W  = $clog2(DATA_W/8 + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_ALL_BYTES  = c_CNT_W'(c_WORD_W/8);
    localparam logic [c_CNT_W-1:0] c_REG_BYTES  = c_CNT_W'(REG_W/8);
    localparam logic [c_RXC_W-1:0] c_DATA_BYTES = c_RXC_W'(DATA_W/8);
    localparam logic [c_RXC_W-1:0] c_RX_ONE     = c_RXC_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYC - 1);

    sccb_state_t         r_state, w_next;
    sccb_cmd_t           w_cmd;
    logic                r_ready_en;
    logic                r_write;
    logic [REG_W-1:0]    r_reg;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;
    logic                r_settle;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [c_RXC_W-1:0]  r_rx_left;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic w_accept, w_tmo_fire, w_rx_hs, w_last_hs;
    logic w_ser_en, w_ser_load, w_ser_valid, w_ser_last;
    logic w_unused;

    assign w_unused   = m_axis_data_tlast;
    assign w_accept   = req_valid && req_ready;
    assign w_rx_hs    = m_axis_data_tvalid && m_axis_data_tready;
    assign w_tmo_fire = (r_state != IDLE) && (r_state != RESP) && (r_tmo == c_TMO_LAST);
    assign w_ser_en   = (r_state == TX_BYTES);
    assign w_ser_load = (r_state == WR_CMD) && s_axis_cmd_ready;
    // Last handshake of a phase opens the settle window before busy is trusted.
    assign w_last_hs  = (w_ser_valid && s_axis_data_tready && w_ser_last)
                     || (w_rx_hs && (r_rx_left == c_RX_ONE));

    sccb_byte_serializer #(
        .WORD_W (c_WORD_W),
        .CNT_W  (c_CNT_W)
    ) u_ser (
        .clk        (clk),
        .reset_     (reset_),
        .load       (w_ser_load),
        .load_word  ({r_reg, r_wdata}),
        .load_count (r_write ? c_ALL_BYTES : c_REG_BYTES),
        .enable     (w_ser_en),
        .tdata      (s_axis_data_tdata),
        .tvalid     (w_ser_valid),
        .tlast      (w_ser_last),
        .tready     (s_axis_data_tready)
    );

    assign s_axis_data_tvalid        = w_ser_valid;
    assign s_axis_data_tlast         = w_ser_valid && w_ser_last;
    assign s_axis_cmd_address        = DEV_ADDR;
    assign s_axis_cmd_start          = w_cmd.start;
    assign s_axis_cmd_read           = w_cmd.read;
    assign s_axis_cmd_write          = w_cmd.write;
    assign s_axis_cmd_write_multiple = w_cmd.write_multiple;
    assign s_axis_cmd_stop           = w_cmd.stop;
    assign rsp_err                   = rsp_valid && r_err;
    assign rsp_rdata                 = r_rsp_rdata;
    assign prescale                  = PRESCALE;
    assign stop_on_idle              = 1'b1;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        w_cmd              = '0;
        req_ready          = 1'b0;
        s_axis_cmd_valid   = 1'b0;
        m_axis_data_tready = 1'b0;
        rsp_valid          = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = r_ready_en;
                if (req_valid && r_ready_en) w_next = WR_CMD;
            end
            WR_CMD: begin
                s_axis_cmd_valid     = 1'b1;
                w_cmd.start          = 1'b1;
                w_cmd.write_multiple = 1'b1;
                w_cmd.stop           = 1'b1;
                if (s_axis_cmd_ready) w_next = TX_BYTES;
            end
            TX_BYTES: begin
                if (w_ser_valid && s_axis_data_tready && w_ser_last)
                    w_next = r_write ? WAIT_IDLE : WAIT_IDLE1;
            end
            WAIT_IDLE1: begin
                if (!r_settle && !busy) w_next = RD_CMD;
            end
            RD_CMD: begin
                // SCCB has no repeated start: only the first read opens, only the last closes.
                s_axis_cmd_valid = 1'b1;
                w_cmd.start      = (r_rx_left == c_DATA_BYTES);
                w_cmd.read       = 1'b1;
                w_cmd.stop       = (r_rx_left == c_RX_ONE);
                if (s_axis_cmd_ready) w_next = RX;
            end
            RX: begin
                m_axis_data_tready = 1'b1;
                if (m_axis_data_tvalid)
                    w_next = (r_rx_left == c_RX_ONE) ? WAIT_IDLE : RD_CMD;
            end
            WAIT_IDLE: begin
                if (!r_settle && !busy) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_tmo_fire) w_next = RESP;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ready_en  <= 1'b0;
            r_write     <= 1'b0;
            r_reg       <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_settle    <= 1'b0;
            r_tmo       <= '0;
            r_rx_left   <= '0;
            r_rx_shift  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_settle   <= w_last_hs;
            if (w_accept) begin
                r_write    <= req_write;
                r_reg      <= req_reg;
                r_wdata    <= req_wdata;
                r_err      <= 1'b0;
                r_tmo      <= '0;
                r_rx_left  <= c_DATA_BYTES;
                r_rx_shift <= '0;
            end else begin
                if (r_state != IDLE)                      r_tmo <= r_tmo + 1'b1;
                if ((missed_ack && r_state != IDLE) || w_tmo_fire) r_err <= 1'b1;
                if (w_rx_hs) begin
                    r_rx_shift <= (r_rx_shift << 8) | DATA_W'(m_axis_data_tdata);
                    r_rx_left  <= r_rx_left - 1'b1;
                end
            end
            // Aborted and write transactions report zero read data.
            if (w_next == RESP && r_state != RESP)
                r_rsp_rdata <= (w_tmo_fire || r_write) ? '0 : r_rx_shift;
        end
    end

endmodule

`default_nettype wire
